// File: rtl/rat_intr_pkg.sv
// rat_intr_pkg: shared state type and default ISR vector for the RAT interrupt controller
package rat_intr_pkg;
    typedef enum logic [1:0] {IDLE, ENTRY, ISR, RESTORE} intr_state_t;
    localparam logic [9:0] DEFAULT_INT_VECTOR = 10'h3FF;
endpackage

// File: rtl/rat_intr_sync.sv
// rat_intr_sync: INTR synchroniser plus rising-edge detector
// Ports: CLK clock, RESET_N sync active-low reset, INTR async input, EDGE one-cycle rising-edge pulse
module rat_intr_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic INTR,
    output logic EDGE
);
    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   prev;
    // prev stays 1 until the reset zeros have drained out of the chain, so an
    // INTR held high across reset is never seen as an edge
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync <= '0;
            fill <= '0;
            prev <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], INTR};
            fill <= {fill[SYNC_STAGES-2:0], 1'b1};
            prev <= fill[SYNC_STAGES-1] ? sync[SYNC_STAGES-1] : 1'b1;
        end
    end
    assign EDGE = sync[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/rat_intr_ctrl.sv
// rat_intr_ctrl: RAT MCU interrupt controller (pending latch, I flag, flag save/restore strobes)
// Ports: CLK, RESET_N (sync active-low), INTR, INSTR_DONE, I_SET, I_CLR, RETI, RETI_IE in;
//        INT_TAKE, INT_VEC, FLG_SHAD_LD, FLG_LD_SEL, FLG_RESTORE, I_FLAG, PENDING out;
//        MISS_CNT[7:0] out only when RAT_INTR_MISS_CNT_EN is defined (saturating dropped-edge count)
module rat_intr_ctrl
    import rat_intr_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [9:0] INT_VECTOR  = DEFAULT_INT_VECTOR
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       INTR,
    input  logic       INSTR_DONE,
    input  logic       I_SET,
    input  logic       I_CLR,
    input  logic       RETI,
    input  logic       RETI_IE,
    output logic       INT_TAKE,
    output logic [9:0] INT_VEC,
    output logic       FLG_SHAD_LD,
    output logic       FLG_LD_SEL,
    output logic       FLG_RESTORE,
    output logic       I_FLAG,
    output logic       PENDING
`ifdef RAT_INTR_MISS_CNT_EN
    ,
    output logic [7:0] MISS_CNT
`endif
);
    intr_state_t state, next_state;
    logic        edge_det;
    logic        reti_ie_q;

    rat_intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .INTR   (INTR),
        .EDGE   (edge_det)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = (PENDING && I_FLAG && INSTR_DONE) ? ENTRY : IDLE;
            ENTRY:   next_state = ISR;
            ISR:     next_state = RETI ? RESTORE : ISR;
            RESTORE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        INT_TAKE    = state == ENTRY;
        FLG_SHAD_LD = state == ENTRY;
        FLG_LD_SEL  = state == RESTORE;
        FLG_RESTORE = state == RESTORE;
    end

    assign INT_VEC = INT_VECTOR;

    // RETI_IE is captured with RETI so the RESTORE cycle need not see it held
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            I_FLAG    <= 1'b0;
            PENDING   <= 1'b0;
            reti_ie_q <= 1'b0;
        end else begin
            if (state == ISR && RETI) reti_ie_q <= RETI_IE;
            PENDING <= (state == ENTRY) ? 1'b0 : (PENDING | edge_det);
            I_FLAG  <= (state == ENTRY)   ? 1'b0 :
                       (state == RESTORE) ? reti_ie_q :
                       I_CLR              ? 1'b0 :
                       I_SET              ? 1'b1 : I_FLAG;
        end
    end

`ifdef RAT_INTR_MISS_CNT_EN
    always_ff @(posedge CLK) begin
        if (!RESET_N) MISS_CNT <= 8'd0;
        else if (edge_det && PENDING && MISS_CNT != 8'hFF) MISS_CNT <= MISS_CNT + 8'd1;
    end
`endif
endmodule
